router_tile_seq: RTL and testbench

- Sequencer for the sequential router datapath: SRAM, address generator (AG), address controller (AC), tile reader and MISO buffer.
- For each output position (o_x, o_y) in an o_size x o_size output map, it:
  - configures the tile window,
  - enables the AG and tile read,
  - enables the AC and waits for read-done,
  - drains the MISO buffer to the PE side,
  - advances the position.
- It replaces bench-driven enable sequencing with a start/busy/done handshake toward the layer controller.

---
 rtl/router_tile_seq.sv | 206 ++++++++++++++++++++
 tb/tb_router_tile_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_tile_seq.sv
// router_tile_seq: start/busy/done sequencer stepping the SRAM tile reader over an o_size x o_size output map.
// Optional WAIT watchdog and sticky error state: define ROUTER_TILE_SEQ_TIMEOUT_EN.
module router_tile_seq #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DRAIN_LEN      = 9,
    parameter int CNT_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH-1:0] i_addr_end,
    input  logic [ADDR_WIDTH-1:0] i_i_size,
    input  logic [ADDR_WIDTH-1:0] i_o_size,
    input  logic                  i_read_done,
    input  logic                  i_miso_valid,
    input  logic                  i_pe_ready,
    output logic                  o_ag_en,
    output logic                  o_tile_read_en,
    output logic                  o_ac_en,
    output logic                  o_miso_pop_en,
    output logic [ADDR_WIDTH-1:0] o_start_addr,
    output logic [ADDR_WIDTH-1:0] o_addr_end,
    output logic [ADDR_WIDTH-1:0] o_o_x,
    output logic [ADDR_WIDTH-1:0] o_o_y,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

`ifdef ROUTER_TILE_SEQ_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_READ, S_WAIT, S_DRAIN, S_NEXT, S_DONE, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_READ, S_WAIT, S_DRAIN, S_NEXT, S_DONE
    } state_t;
`endif

    if (DRAIN_LEN < 1 || DRAIN_LEN >= 2**CNT_WIDTH) begin : g_bad_drain_len
        $error("DRAIN_LEN must be in 1 .. 2**CNT_WIDTH-1");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= 2**CNT_WIDTH) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1 .. 2**CNT_WIDTH-1");
    end

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] i_size_q;
    logic [ADDR_WIDTH-1:0] o_size_q;
    logic [ADDR_WIDTH-1:0] last_idx;
    logic [CNT_WIDTH-1:0]  drain_cnt;
    logic                  pop;
    logic                  drain_last;
    logic                  last_tile;

    assign pop        = (state == S_DRAIN) && i_miso_valid && i_pe_ready;
    assign drain_last = (drain_cnt == CNT_WIDTH'(DRAIN_LEN - 1));
    assign last_idx   = o_size_q - ADDR_WIDTH'(1);
    assign last_tile  = (o_o_x == last_idx) && (o_o_y == last_idx);

`ifdef ROUTER_TILE_SEQ_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] wdog;
    logic                 err_q;
    logic                 wdog_hit;

    assign wdog_hit = (wdog == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    assign o_err    = err_q;
`else
    assign o_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (i_start) state_next = (i_o_size == '0) ? S_DONE : S_SETUP;
            S_SETUP: state_next = S_READ;
            S_READ:  state_next = S_WAIT;
            S_WAIT: begin
                if (i_read_done) begin
                    state_next = S_DRAIN;
                end
`ifdef ROUTER_TILE_SEQ_TIMEOUT_EN
                else if (wdog_hit) begin
                    state_next = S_ERR;
                end
`endif
            end
            S_DRAIN: if (pop && drain_last) state_next = S_NEXT;
            S_NEXT:  state_next = last_tile ? S_DONE : S_SETUP;
            S_DONE:  state_next = S_IDLE;
`ifdef ROUTER_TILE_SEQ_TIMEOUT_EN
            S_ERR:   state_next = S_ERR;
`endif
            default: state_next = S_IDLE;
        endcase
        if (i_abort) begin
            state_next = S_IDLE;
        end
    end

    always_comb begin
        o_ag_en        = 1'b0;
        o_tile_read_en = 1'b0;
        o_ac_en        = 1'b0;
        o_miso_pop_en  = 1'b0;
        o_done         = 1'b0;
        o_busy         = (state != S_IDLE);
        unique case (state)
            S_SETUP, S_NEXT: o_ag_en = 1'b1;
            S_READ: begin
                o_ag_en        = 1'b1;
                o_tile_read_en = 1'b1;
            end
            S_WAIT: begin
                o_ag_en        = 1'b1;
                o_tile_read_en = 1'b1;
                o_ac_en        = 1'b1;
            end
            S_DRAIN: begin
                o_ag_en       = 1'b1;
                o_miso_pop_en = pop;
            end
            S_DONE:  o_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            base_q       <= '0;
            i_size_q     <= '0;
            o_size_q     <= '0;
            o_addr_end   <= '0;
            o_start_addr <= '0;
            o_o_x        <= '0;
            o_o_y        <= '0;
            drain_cnt    <= '0;
`ifdef ROUTER_TILE_SEQ_TIMEOUT_EN
            wdog         <= '0;
            err_q        <= 1'b0;
`endif
        end else if (i_abort) begin
            o_o_x     <= '0;
            o_o_y     <= '0;
            drain_cnt <= '0;
`ifdef ROUTER_TILE_SEQ_TIMEOUT_EN
            wdog      <= '0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_start) begin
                        base_q     <= i_base_addr;
                        o_addr_end <= i_addr_end;
                        i_size_q   <= i_i_size;
                        o_size_q   <= i_o_size;
                        o_o_x      <= '0;
                        o_o_y      <= '0;
`ifdef ROUTER_TILE_SEQ_TIMEOUT_EN
                        err_q      <= 1'b0;
`endif
                    end
                end
                // Products wrap mod 2^ADDR_WIDTH, matching the SRAM address space.
                S_SETUP: o_start_addr <= base_q + o_o_y * i_size_q + o_o_x;
`ifdef ROUTER_TILE_SEQ_TIMEOUT_EN
                S_READ:  wdog <= '0;
                S_WAIT: begin
                    wdog <= wdog + CNT_WIDTH'(1);
                    if (wdog_hit && !i_read_done) begin
                        err_q <= 1'b1;
                    end
                end
`endif
                S_DRAIN: begin
                    if (pop) begin
                        drain_cnt <= drain_last ? '0 : drain_cnt + CNT_WIDTH'(1);
                    end
                end
                S_NEXT: begin
                    if (o_o_x != last_idx) begin
                        o_o_x <= o_o_x + ADDR_WIDTH'(1);
                    end else begin
                        o_o_x <= '0;
                        o_o_y <= o_o_y + ADDR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_router_tile_seq.sv
// Scoreboard bench for router_tile_seq: stimulus queues expected tile origins, a monitor pops and compares them.
module tb_router_tile_seq;
    localparam int AW         = 8;
    localparam int DLEN       = 9;
    localparam int TB_TIMEOUT = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW-1:0] aend = '0;
    logic [AW-1:0] isz = '0;
    logic [AW-1:0] osz = '0;
    logic          read_done = 1'b0;
    logic          miso_valid = 1'b1;
    logic          pe_ready = 1'b1;
    logic          ag_en, tile_read_en, ac_en, pop_en, busy, done, err;
    logic [AW-1:0] start_addr, addr_end, ox, oy;

    always #5 clk = ~clk;

    router_tile_seq #(
        .ADDR_WIDTH    (AW),
        .DRAIN_LEN     (DLEN),
        .CNT_WIDTH     (8),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_abort       (abort),
        .i_base_addr   (base),
        .i_addr_end    (aend),
        .i_i_size      (isz),
        .i_o_size      (osz),
        .i_read_done   (read_done),
        .i_miso_valid  (miso_valid),
        .i_pe_ready    (pe_ready),
        .o_ag_en       (ag_en),
        .o_tile_read_en(tile_read_en),
        .o_ac_en       (ac_en),
        .o_miso_pop_en (pop_en),
        .o_start_addr  (start_addr),
        .o_addr_end    (addr_end),
        .o_o_x         (ox),
        .o_o_y         (oy),
        .o_busy        (busy),
        .o_done        (done),
        .o_err         (err)
    );

    int checks = 0;
    int failures = 0;
    logic [AW-1:0] exp_origin[$];
    int pops = 0;
    int done_cnt = 0;
    int en_cycles = 0;
    int drain_len = 0;

    bit auto_done = 1'b1;
    bit toggle_ready = 1'b0;
    int hold_tile = -1;
    int wait_idx = -1;
    int wait_cyc = 0;
    bit r_prev_ac = 1'b0;

    bit m_prev_ac = 1'b0;
    bit in_drain = 1'b0;
    int tile_pops = 0;
    int dcyc = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: samples mid-cycle, compares tile origins in READ against the scoreboard queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tile_read_en && !ac_en) begin
                    if (exp_origin.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL tile_origin_unexpected actual=%0d expected=none", start_addr);
                    end else begin
                        check("tile_origin", int'(start_addr), int'(exp_origin.pop_front()));
                    end
                end
                if (pop_en) pops++;
                if (done) done_cnt++;
                if (ag_en || tile_read_en || ac_en || pop_en) en_cycles++;
                if (m_prev_ac && !ac_en && ag_en) begin
                    in_drain  = 1'b1;
                    dcyc      = 0;
                    tile_pops = 0;
                end
                if (in_drain) begin
                    dcyc++;
                    if (pop_en) begin
                        tile_pops++;
                        if (tile_pops == DLEN) begin
                            drain_len = dcyc;
                            in_drain  = 1'b0;
                        end
                    end
                end
                m_prev_ac = ac_en;
            end
        end
    end

    // Responder: tile reader finishes in the 4th WAIT cycle; optional 1/0 ready pattern from DRAIN entry.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ac_en) begin
                if (!r_prev_ac) begin
                    wait_cyc = 0;
                    wait_idx++;
                end
                wait_cyc++;
                read_done = auto_done && (wait_idx != hold_tile) && (wait_cyc == 4);
            end else begin
                read_done = 1'b0;
            end
            if (toggle_ready) begin
                pe_ready = (r_prev_ac && !ac_en && ag_en) ? 1'b1 : ~pe_ready;
            end else begin
                pe_ready = 1'b1;
            end
            r_prev_ac = ac_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] e,
                            input logic [AW-1:0] is, input logic [AW-1:0] os);
        base     = b;
        aend     = e;
        isz      = is;
        osz      = os;
        wait_idx = -1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        base  = 8'h5A;
        aend  = 8'h00;
        isz   = 8'd7;
        osz   = 8'd9;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == d0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done expected=done_within_%0d", name, budget);
        end
    endtask

    task automatic push_list(input int n, input logic [AW-1:0] v[16]);
        for (int i = 0; i < n; i++) exp_origin.push_back(v[i]);
    endtask

    logic [AW-1:0] full_list[16] = '{8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12,
                                     8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [AW-1:0] wrap_list[16] = '{8'd250, 8'd251, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                                     8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

    initial begin
        int n;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_busy", int'(busy), 0);
        check("reset_enables", int'({ag_en, tile_read_en, ac_en, pop_en}), 0);
        check("reset_done_err", int'({done, err}), 0);
        check("reset_start_addr", int'(start_addr), 0);
        check("reset_coords", int'({ox, oy}), 0);
        check("reset_addr_end", int'(addr_end), 0);

        // Full 3x3 run over a 5-wide input map.
        pops = 0; done_cnt = 0;
        push_list(9, full_list);
        do_start(8'd0, 8'd24, 8'd5, 8'd3);
        check("start_to_ag_en", int'(ag_en), 1);
        check("addr_end_latched", int'(addr_end), 24);
        wait_done("full", 400);
        check("full_pops", pops, 81);
        check("full_busy_after", int'(busy), 0);
        repeat (3) tick();
        check("full_done_pulses", done_cnt, 1);
        check("full_queue_empty", exp_origin.size(), 0);

        // Origin wrap mod 256.
        push_list(4, wrap_list);
        do_start(8'd250, 8'd255, 8'd5, 8'd2);
        wait_done("wrap", 200);
        check("wrap_queue_empty", exp_origin.size(), 0);

        // Zero-size map: DONE in the cycle after the start cycle, nothing enabled.
        en_cycles = 0; done_cnt = 0;
        do_start(8'd0, 8'd0, 8'd5, 8'd0);
        check("zero_done_high", int'(done), 1);
        tick();
        check("zero_done_low", int'(done), 0);
        check("zero_busy_low", int'(busy), 0);
        check("zero_done_pulses", done_cnt, 1);
        check("zero_enables", en_cycles, 0);

        // Backpressure: ready alternates 1/0 starting on DRAIN entry.
        toggle_ready = 1'b1; pops = 0; drain_len = 0;
        exp_origin.push_back(8'd3);
        do_start(8'd3, 8'd40, 8'd5, 8'd1);
        wait_done("bp", 200);
        check("bp_drain_len", drain_len, 17);
        check("bp_pops", pops, 9);
        toggle_ready = 1'b0;

        // Abort during tile (1,1) WAIT, then restart.
        hold_tile = 4; done_cnt = 0;
        for (int i = 0; i < 5; i++) exp_origin.push_back(full_list[i]);
        do_start(8'd0, 8'd24, 8'd5, 8'd3);
        n = 0;
        while (!(ac_en && ox == 8'd1 && oy == 8'd1) && n < 200) begin
            tick();
            n++;
        end
        check("abort_reached_wait11", int'(ac_en && ox == 8'd1 && oy == 8'd1), 1);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_enables", int'({ag_en, tile_read_en, ac_en, pop_en}), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_coords", int'({ox, oy}), 0);
        repeat (3) tick();
        check("abort_no_done", done_cnt, 0);
        check("abort_queue_empty", exp_origin.size(), 0);

        hold_tile = -1; pops = 0;
        push_list(9, full_list);
        do_start(8'd0, 8'd24, 8'd5, 8'd3);
        check("restart_coords", int'({ox, oy}), 0);
        repeat (4) tick();
        start = 1'b1;
        base  = 8'd100;
        tick();
        start = 1'b0;
        wait_done("restart", 400);
        check("restart_pops", pops, 81);
        check("restart_queue_empty", exp_origin.size(), 0);

`ifdef ROUTER_TILE_SEQ_TIMEOUT_EN
        // Watchdog: read_done never arrives.
        hold_tile = 0;
        exp_origin.push_back(8'd0);
        do_start(8'd0, 8'd24, 8'd5, 8'd1);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (ac_en) n++;
            else if (n > 0) break;
        end
        check("to_wait_cycles", n, TB_TIMEOUT);
        check("to_err", int'(err), 1);
        check("to_enables", int'({ag_en, tile_read_en, ac_en, pop_en}), 0);
        check("to_busy", int'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("to_err_sticky", int'(err), 1);
        hold_tile = -1;
        exp_origin.push_back(8'd0);
        do_start(8'd0, 8'd24, 8'd5, 8'd1);
        check("to_err_cleared", int'(err), 0);
        wait_done("to_rerun", 200);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
